// File: rtl/table_player_pkg.sv
// Shared types and width helpers for the multi-channel table sequencer.
package table_player_pkg;

  typedef enum logic [1:0] {
    ONESHOT  = 2'd0,
    LOOP     = 2'd1,
    PINGPONG = 2'd2,
    RSVD     = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int chan_w(input int n_chan);
    return (n_chan > 1) ? $clog2(n_chan) : 1;
  endfunction

endpackage

// File: rtl/table_player_mem.sv
// N_CHAN x DEPTH sample store with range-checked write port and one shared,
// registered read address (read-before-write on a same-cycle collision).
module table_player_mem
  import table_player_pkg::*;
#(
  parameter  int N_CHAN = 2,
  parameter  int DEPTH  = 4,
  parameter  int WIDTH  = 16,
  localparam int AW     = addr_w(DEPTH),
  localparam int CW     = chan_w(N_CHAN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [CW-1:0]            i_wr_chan,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic signed [WIDTH-1:0]  i_wr_data,
  input  logic                     i_rd_en,
  input  logic [AW-1:0]            i_rd_addr,
  output logic [N_CHAN*WIDTH-1:0]  o_rd_data
);

  logic signed [WIDTH-1:0] r_mem [N_CHAN][DEPTH];
  logic signed [WIDTH-1:0] r_rd  [N_CHAN];
  logic                    w_wr_ok;

  // Out-of-range writes are silently dropped; contents survive reset.
  assign w_wr_ok = i_wr_en && (32'(i_wr_chan) < N_CHAN) && (32'(i_wr_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_wr_chan][i_wr_addr] <= i_wr_data;
  end

  for (genvar k = 0; k < N_CHAN; k++) begin : g_rd
    always_ff @(posedge clk) begin
      if (rst)          r_rd[k] <= '0;
      else if (i_rd_en) r_rd[k] <= r_mem[k][i_rd_addr];
    end
    assign o_rd_data[k*WIDTH +: WIDTH] = r_rd[k];
  end

endmodule

// File: rtl/table_player.sv
// Multi-channel lookup-table sequencer: walks its own address in one-shot,
// loop or ping-pong order, holding each sample for div+1 cycles.
//
// state | meaning
// IDLE  | waiting for start; addr and data hold their last values
// RUN   | hold counter running, address stepping per latched mode
module table_player
  import table_player_pkg::*;
#(
  parameter  int N_CHAN = 2,
  parameter  int DEPTH  = 4,
  parameter  int WIDTH  = 16,
  parameter  int DIV_W  = 8,
  localparam int AW     = addr_w(DEPTH),
  localparam int CW     = chan_w(N_CHAN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CW-1:0]            wr_chan,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         div,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [AW-1:0]            addr,
  output logic [N_CHAN*WIDTH-1:0]  data,
  output logic                     valid,
  output logic                     done
);

  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

  state_t           r_state;
  mode_t            r_mode;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_tick;
  logic [AW-1:0]    r_addr;
  logic             r_dir_dn;
  logic             r_valid;
  logic             r_done;
  logic             w_rd_en;

  assign w_rd_en = (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= ONESHOT;
      r_div    <= '0;
      r_tick   <= '0;
      r_addr   <= '0;
      r_dir_dn <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // valid tracks the read issued this cycle, so it lags addr by one
      r_valid <= (r_state == RUN);
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state  <= RUN;
            r_mode   <= mode_t'(mode);
            r_div    <= div;
            r_tick   <= '0;
            r_addr   <= '0;
            r_dir_dn <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (r_tick != r_div) begin
            r_tick <= r_tick + 1'b1;
          end else begin
            r_tick <= '0;
            case (r_mode)
              LOOP: r_addr <= (r_addr == A_LAST) ? '0 : r_addr + 1'b1;
              PINGPONG: begin
                // endpoints are visited once per sweep; a 1-entry table never moves
                if (DEPTH == 1) begin
                  r_addr <= '0;
                end else if (!r_dir_dn) begin
                  if (r_addr == A_LAST) begin
                    r_addr   <= r_addr - 1'b1;
                    r_dir_dn <= 1'b1;
                  end else begin
                    r_addr <= r_addr + 1'b1;
                  end
                end else begin
                  if (r_addr == '0) begin
                    r_addr   <= r_addr + 1'b1;
                    r_dir_dn <= 1'b0;
                  end else begin
                    r_addr <= r_addr - 1'b1;
                  end
                end
              end
              default: begin
                if (r_addr == A_LAST) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_addr <= r_addr + 1'b1;
                end
              end
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  table_player_mem #(
    .N_CHAN (N_CHAN),
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en),
    .i_wr_chan (wr_chan),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_addr),
    .o_rd_data (data)
  );

  assign busy  = (r_state == RUN);
  assign addr  = r_addr;
  assign valid = r_valid;
  assign done  = r_done;

endmodule

// File: tb/tb_table_player.sv
// Scoreboard bench for table_player: default build plus DEPTH=3 and DEPTH=1 builds.
module tb_table_player;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_m, wr_en_3, wr_en_1;
  logic [0:0]  wr_chan;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic        start_m, start_3, start_1, stop;

  logic        busy_m, valid_m, done_m;
  logic [1:0]  addr_m;
  logic [31:0] data_m;
  logic        busy_3, valid_3, done_3;
  logic [1:0]  addr_3;
  logic [31:0] data_3;
  logic        busy_1, valid_1, done_1;
  logic [0:0]  addr_1;
  logic [31:0] data_1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  logic [15:0] tbl [2][D];
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  table_player u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en_m), .wr_chan(wr_chan), .wr_addr(wr_addr),
    .wr_data(wr_data), .mode(mode), .div(div), .start(start_m), .stop(stop),
    .busy(busy_m), .addr(addr_m), .data(data_m), .valid(valid_m), .done(done_m)
  );

  table_player #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .wr_en(wr_en_3), .wr_chan(wr_chan), .wr_addr(wr_addr),
    .wr_data(wr_data), .mode(mode), .div(div), .start(start_3), .stop(stop),
    .busy(busy_3), .addr(addr_3), .data(data_3), .valid(valid_3), .done(done_3)
  );

  table_player #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .wr_en(wr_en_1), .wr_chan(wr_chan), .wr_addr(wr_addr[0:0]),
    .wr_data(wr_data), .mode(mode), .div(div), .start(start_1), .stop(stop),
    .busy(busy_1), .addr(addr_1), .data(data_1), .valid(valid_1), .done(done_1)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address of the k-th played sample for the default DEPTH=4 build.
  function automatic int seq_addr(input int md, input int k);
    int per, p;
    if (md == 1) return k % D;
    if (md == 2) begin
      per = 2 * (D - 1);
      p   = k % per;
      return (p < D) ? p : per - p;
    end
    return (k < D) ? k : D - 1;
  endfunction

  // One expected output word per RUN cycle of the default build.
  task automatic push_cycles(input int md, input int dv, input int n);
    int a;
    for (int c = 0; c < n; c++) begin
      a = seq_addr(md, c / (dv + 1));
      sb_q.push_back({tbl[1][a], tbl[0][a]});
    end
  endtask

  task automatic wr(input int inst, input int ch, input int ad, input logic [15:0] d);
    wr_chan = 1'(ch);
    wr_addr = 2'(ad);
    wr_data = d;
    wr_en_m = (inst == 0);
    wr_en_3 = (inst == 3);
    wr_en_1 = (inst == 1);
    step();
    wr_en_m = 1'b0;
    wr_en_3 = 1'b0;
    wr_en_1 = 1'b0;
    if (inst == 0 && ad < D) tbl[ch][ad] = d;
  endtask

  task automatic run_oneshot(input int dv);
    push_cycles(0, dv, D * (dv + 1));
    mode = 2'd0; div = 8'(dv); start_m = 1'b1;
    step();
    start_m = 1'b0;
    repeat (D * (dv + 1) + 1) step();
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (valid_m) begin
      if (sb_q.size() == 0) chk("sb_extra", 64'(sb_q.size()), 64'd1);
      else begin
        e = sb_q.pop_front();
        chk("sb_data", data_m, e);
      end
    end
    if (done_m) n_done++;
  end

  initial begin
    rst = 1'b1;
    wr_en_m = 0; wr_en_3 = 0; wr_en_1 = 0;
    wr_chan = '0; wr_addr = '0; wr_data = '0;
    mode = '0; div = '0; start_m = 0; start_3 = 0; start_1 = 0; stop = 0;
    step(); step();
    chk("rst_busy", busy_m, 0);
    chk("rst_valid", valid_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_addr", addr_m, 0);
    chk("rst_data", data_m, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < D; i++) begin
      wr(0, 0, i, 16'(10 * (i + 1)));
      wr(0, 1, i, 16'(-(i + 1)));
    end

    // ONESHOT, div=0: cycle-accurate addr/done/valid on top of the scoreboard
    push_cycles(0, 0, D);
    mode = 2'd0; div = 8'd0; start_m = 1'b1;
    step();
    start_m = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) chk("os_addr", addr_m, 64'(c - 1));
      chk("os_busy", busy_m, (c <= 4));
      chk("os_done", done_m, (c == 5));
      step();
    end
    step();
    chk("os_idle_valid", valid_m, 0);
    chk("os_idle_data", data_m, {16'hFFFC, 16'd40});
    chk("os_idle_addr", addr_m, 3);
    chk("os_drain", 64'(sb_q.size()), 0);
    chk("os_done_cnt", n_done, 1);

    // LOOP, div=2, ignored start/mode/div changes mid-run, then stop
    push_cycles(1, 2, 14);
    mode = 2'd1; div = 8'd2; start_m = 1'b1;
    step();
    start_m = 1'b0;
    for (int c = 1; c < 14; c++) begin
      if (c == 3) begin start_m = 1'b1; mode = 2'd0; div = 8'd0; end
      if (c == 7) start_m = 1'b0;
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("lp_stop_busy", busy_m, 0);
    chk("lp_stop_valid1", valid_m, 1);
    step();
    chk("lp_stop_valid0", valid_m, 0);
    chk("lp_stop_addr", addr_m, 0);
    chk("lp_stop_data", data_m, {16'hFFFF, 16'd10});
    chk("lp_drain", 64'(sb_q.size()), 0);
    chk("lp_done_cnt", n_done, 1);

    // PINGPONG, div=0: 10,20,30,40,30,20,10,20
    push_cycles(2, 0, 8);
    mode = 2'd2; div = 8'd0; start_m = 1'b1;
    step();
    start_m = 1'b0;
    repeat (7) step();
    chk("pp_addr", addr_m, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    chk("pp_drain", 64'(sb_q.size()), 0);

    // start and stop together in IDLE: stop wins
    start_m = 1'b1; stop = 1'b1;
    step();
    start_m = 1'b0; stop = 1'b0;
    chk("ss_busy", busy_m, 0);
    chk("ss_addr", addr_m, 1);
    step();
    chk("ss_busy2", busy_m, 0);

    // same-cycle write to the entry being read returns the old value
    push_cycles(0, 0, D);
    mode = 2'd0; div = 8'd0; start_m = 1'b1;
    step();
    start_m = 1'b0;
    step(); step();
    chk("rbw_addr", addr_m, 2);
    wr_en_m = 1'b1; wr_chan = 1'b0; wr_addr = 2'd2; wr_data = 16'd99;
    step();
    wr_en_m = 1'b0;
    tbl[0][2] = 16'd99;
    step(); step();
    chk("rbw_drain", 64'(sb_q.size()), 0);
    run_oneshot(0);
    chk("rbw2_drain", 64'(sb_q.size()), 0);
    chk("rbw_done_cnt", n_done, 3);

    // reset mid-LOOP, then replay without reloading
    push_cycles(1, 1, 5);
    mode = 2'd1; div = 8'd1; start_m = 1'b1;
    step();
    start_m = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", busy_m, 0);
    chk("mr_valid", valid_m, 0);
    chk("mr_data", data_m, 0);
    chk("mr_addr", addr_m, 0);
    chk("mr_done", done_m, 0);
    chk("mr_drain", 64'(sb_q.size()), 0);
    run_oneshot(1);
    chk("mr_replay_drain", 64'(sb_q.size()), 0);
    chk("mr_replay_busy", busy_m, 0);
    chk("mr_done_cnt", n_done, 4);

    // DEPTH=3 build: out-of-range write dropped, loop wraps 2 -> 0
    for (int i = 0; i < 3; i++) begin
      wr(3, 0, i, 16'(i + 1));
      wr(3, 1, i, 16'(i + 4));
    end
    wr(3, 0, 3, 16'd77);
    mode = 2'd1; div = 8'd0; start_3 = 1'b1;
    step();
    start_3 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk("d3_addr", addr_3, 64'((c - 1) % 3));
      if (c >= 2) chk("d3_data", data_3, {16'(((c - 2) % 3) + 4), 16'(((c - 2) % 3) + 1)});
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("d3_busy", busy_3, 0);

    // DEPTH=1 build: ping-pong stays at 0, write to addr 1 dropped
    wr(1, 0, 0, 16'd55);
    wr(1, 1, 0, 16'hFFF9);
    wr(1, 0, 1, 16'd66);
    mode = 2'd2; div = 8'd0; start_1 = 1'b1;
    step();
    start_1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("d1_addr", addr_1, 0);
      if (c >= 2) chk("d1_data", data_1, {16'hFFF9, 16'd55});
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    chk("d1_busy", busy_1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/table_player.md
Name: table_player

Overview:
- Parametrised multi-channel lookup-table sequencer; the successor to the single-channel, externally addressed array block.
- Holds N_CHAN tables of DEPTH signed fixed-point samples. Tables are writable at run time.
- Walks its own address in one-shot, loop or ping-pong mode, holding each sample for a programmable number of cycles.
- Drives stimulus/waveform inputs of msdsl-generated analog models in the testbenches.

Parameters:
- N_CHAN, 2, number of independent tables/output channels (>=1)
- DEPTH, 4, entries per table (>=1, need not be a power of two)
- WIDTH, 16, signed fixed-point sample width (matches the real-type width used by the model)
- DIV_W, 8, width of the hold-count divider

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  table write strobe
- wr_chan  in  max(1,$clog2(N_CHAN))  channel being written
- wr_addr  in  max(1,$clog2(DEPTH))  entry being written
- wr_data  in  WIDTH  sample value, signed
- mode  in  2  0=ONESHOT, 1=LOOP, 2=PINGPONG, 3=reserved (treated as ONESHOT); latched on start
- div  in  DIV_W  each sample is held div+1 cycles; latched on start
- start  in  1  begin playback (accepted only in IDLE)
- stop  in  1  abort playback
- busy  out  1  high in RUN
- addr  out  max(1,$clog2(DEPTH))  current table address
- data  out  N_CHAN*WIDTH  registered samples; channel k is at [k*WIDTH +: WIDTH]
- valid  out  1  data holds a played sample
- done  out  1  one-cycle pulse on natural one-shot completion

Behaviour:
- Reset (sync, rst=1 at a clock edge): state=IDLE, addr=0, dir=up, tick=0, data=0, valid=0, done=0, busy=0. Table contents are NOT reset. A reset mid-run returns to IDLE on the next edge with no done pulse.
- States: IDLE, RUN. A dir bit (up/down) is used only in PINGPONG.
- IDLE->RUN when start=1 and stop=0:
  - latch mode and div; addr=0, tick=0, dir=up.
  - start accepted at edge t gives busy=1 and addr=0 from t+1.
- start while in RUN is ignored. start and stop together in IDLE: stop wins, nothing happens.
- RUN, hold counter: tick increments each cycle. When tick==div_latched, tick returns to 0 and addr steps.
- Stepping by mode:
  - LOOP: DEPTH-1 wraps to 0.
  - PINGPONG: endpoints are not repeated (DEPTH=4 gives 0,1,2,3,2,1,0,1,...). DEPTH=1 stays at 0.
  - ONESHOT: at addr==DEPTH-1 with tick==div, next state is IDLE and addr stays at DEPTH-1.
- stop=1 in RUN: IDLE on the next edge. valid drops one cycle later. No done. addr and data hold their values.
- Read path, latency 1: data <= table[k][addr] every cycle.
  - valid <= (state==RUN), so valid/data lag addr by exactly one cycle.
  - Each sample is therefore valid for div+1 consecutive cycles.
  - In IDLE, data holds its last value and valid=0.
- done: asserted in the cycle after the ONESHOT RUN->IDLE transition. This coincides with the last valid cycle of sample DEPTH-1.
- Writes:
  - Accepted in any state, including RUN. Take effect at the edge.
  - A write to the entry being read in the same cycle returns the OLD value (read-before-write). The new value is seen on the next read.
  - wr_addr>=DEPTH or wr_chan>=N_CHAN: write is dropped.
- Changes to mode/div during RUN have no effect until the next start.
- Arithmetic:
  - Samples are stored and output unmodified, with no scaling or saturation.
  - tick and addr are unsigned, with wrap handled explicitly as above (never natural overflow).

Decomposition:
- table_player_pkg holds: mode_t enum (ONESHOT, LOOP, PINGPONG, RSVD); state_t enum (IDLE, RUN); address/channel width helper functions.
- Sub-module table_player_mem contains:
  - the N_CHAN x DEPTH register array
  - the write port with range check
  - a shared read address and registered read-before-write output
- The top level holds only the FSM, tick counter and address/dir logic.

Test Plan:
- Load ch0={10,20,30,40}, ch1={-1,-2,-3,-4}; ONESHOT, div=0, start at cycle 0 -> addr 0,1,2,3 at cycles 1-4; data ch0 10,20,30,40 with valid=1 at cycles 2-5; done=1 only at cycle 5; valid=0 and data still 40/-4 at cycle 6.
- LOOP, div=2 -> each value valid for 3 cycles; sequence 10,20,30,40,10,...; stop asserted at an arbitrary cycle -> busy=0 next cycle, valid=0 one cycle later, done never pulses.
- PINGPONG, div=0 -> ch0 data sequence 10,20,30,40,30,20,10,20; with DEPTH=1 build, data constant.
- Write ch0[2]=99 in the same cycle addr==2 -> that sample reads 30, next visit reads 99; write with wr_addr>=DEPTH (DEPTH=3 build) leaves all entries unchanged.
- start while busy, and start+stop together in IDLE -> no state change; mode/div changed mid-run -> playback timing unchanged.
- rst asserted mid-LOOP -> next cycle: busy=0, valid=0, data=0, addr=0, done=0; restart without reloading reproduces the previously loaded values.
